// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response bus used by if_fetch_ctrl.
// master: fetch controller side, slave: instruction memory side.
interface if_fetch_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              im_req_valid;
    logic              im_req_ready;
    logic [ADDR_W-1:0] im_req_addr;
    logic              im_rsp_valid;
    logic [31:0]       im_rsp_data;

    modport master (
        output im_req_valid,
        output im_req_addr,
        input  im_req_ready,
        input  im_rsp_valid,
        input  im_rsp_data
    );

    modport slave (
        input  im_req_valid,
        input  im_req_addr,
        output im_req_ready,
        output im_rsp_valid,
        output im_rsp_data
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller sitting in front of the PC register.
// Issues one instruction-memory request at a time, holds the returned
// instruction for ID, and only lets the PC move on delivery to ID or on a
// redirect. Responses made stale by a redirect are discarded.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch/drop counters.
//
// state  | meaning
// S_REQ  | request valid at current_pc, waiting for memory to accept
// S_WAIT | one request outstanding, waiting for its response
// S_HOLD | instruction held for ID, waiting for id_ready
module if_fetch_ctrl #(
    parameter int ADDR_W = 32,
    parameter int PC_INC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   i_current_pc,
    output logic [ADDR_W-1:0]   o_next_pc,
    output logic                o_fetch_stall,
    input  logic                i_redirect_valid,
    input  logic [ADDR_W-1:0]   i_redirect_pc,
    if_fetch_ctrl_if.master     im,
    output logic                o_inst_valid,
    output logic [31:0]         o_inst_out,
    output logic [ADDR_W-1:0]   o_inst_pc,
    input  logic                i_id_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         o_perf_fetch_cnt,
    output logic [31:0]         o_perf_drop_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_drop_rsp;
    logic              w_drop_nxt;
    logic              w_req_valid;
    logic              w_advance;
    logic              w_deliver;
    logic              w_latch_pc;
    logic [ADDR_W-1:0] r_pc_q;
    logic              r_inst_valid;
    logic [31:0]       r_inst_out;
    logic [ADDR_W-1:0] r_inst_pc;

    // State and stale-response flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_REQ;
            r_drop_rsp <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_drop_rsp <= w_drop_nxt;
        end
    end

    // Next-state decode; a redirect overrides delivery and advance
    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop_rsp;
        w_req_valid = 1'b0;
        w_advance   = 1'b0;
        w_deliver   = 1'b0;
        w_latch_pc  = 1'b0;
        case (r_state)
            S_REQ: begin
                w_req_valid = 1'b1;
                if (im.im_req_ready) begin
                    w_latch_pc  = 1'b1;
                    w_state_nxt = S_WAIT;
                    // request accepted while PC is being redirected: its data is stale
                    w_drop_nxt  = i_redirect_valid;
                end
            end
            S_WAIT: begin
                if (im.im_rsp_valid) begin
                    w_drop_nxt = 1'b0;
                    if (r_drop_rsp || i_redirect_valid) begin
                        w_state_nxt = S_REQ;
                    end else begin
                        w_deliver   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else if (i_redirect_valid) begin
                    w_drop_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (i_redirect_valid) begin
                    w_state_nxt = S_REQ;
                end else if (i_id_ready) begin
                    w_advance   = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    // Request PC capture and held-instruction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_q       <= '0;
            r_inst_valid <= 1'b0;
            r_inst_out   <= '0;
            r_inst_pc    <= '0;
        end else begin
            if (w_latch_pc) begin
                r_pc_q <= i_current_pc;
            end
            if (w_deliver) begin
                r_inst_out <= im.im_rsp_data;
                r_inst_pc  <= r_pc_q;
            end
            r_inst_valid <= (w_state_nxt == S_HOLD);
        end
    end

    assign im.im_req_valid = w_req_valid;
    assign im.im_req_addr  = i_current_pc;
    assign o_inst_valid    = r_inst_valid;
    assign o_inst_out      = r_inst_out;
    assign o_inst_pc       = r_inst_pc;
    assign o_fetch_stall   = ~(i_redirect_valid | w_advance);
    assign o_next_pc       = i_redirect_valid ? i_redirect_pc :
                             w_advance        ? i_current_pc + ADDR_W'(PC_INC) :
                                                i_current_pc;

`ifdef FETCH_PERF_CNT_EN
    logic        w_drop_evt;
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_drop_cnt;

    // A drop is either a discarded response or a held instruction killed by redirect
    assign w_drop_evt = ((r_state == S_WAIT) && im.im_rsp_valid && (r_drop_rsp || i_redirect_valid)) ||
                        ((r_state == S_HOLD) && i_redirect_valid);

    // Saturating counters, untouched by redirects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch_cnt <= '0;
            r_perf_drop_cnt  <= '0;
        end else begin
            if (w_advance && (r_perf_fetch_cnt != 32'hFFFF_FFFF)) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            end
            if (w_drop_evt && (r_perf_drop_cnt != 32'hFFFF_FFFF)) begin
                r_perf_drop_cnt <= r_perf_drop_cnt + 32'd1;
            end
        end
    end

    assign o_perf_fetch_cnt = r_perf_fetch_cnt;
    assign o_perf_drop_cnt  = r_perf_drop_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios followed by
// randomized traffic, all checked every cycle against a transaction-level
// model (outstanding request / stale flag / held instruction).
module tb_if_fetch_ctrl;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] current_pc;
    logic [AW-1:0] next_pc;
    logic          fetch_stall;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          inst_valid;
    logic [31:0]   inst_out;
    logic [AW-1:0] inst_pc;
    logic          id_ready;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   perf_fetch;
    logic [31:0]   perf_drop;
`endif

    if_fetch_ctrl_if #(.ADDR_W(AW)) im ();

    always #5 clk = ~clk;

    if_fetch_ctrl #(.ADDR_W(AW), .PC_INC(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_current_pc     (current_pc),
        .o_next_pc        (next_pc),
        .o_fetch_stall    (fetch_stall),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .im               (im),
        .o_inst_valid     (inst_valid),
        .o_inst_out       (inst_out),
        .o_inst_pc        (inst_pc),
        .i_id_ready       (id_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_perf_fetch_cnt (perf_fetch),
        .o_perf_drop_cnt  (perf_drop)
`endif
    );

    int checks = 0;
    int errors = 0;

    // model state
    bit          m_out, m_stale, m_held;
    logic [31:0] m_hdata, m_hpc, m_reqpc;
    int unsigned m_fetch, m_drop;
    // memory state
    bit          mem_pend;
    int          mem_dly;
    logic [31:0] mem_addr;
    // stimulus knobs
    bit          s_redirect, s_id_ready, s_ready, s_bad_data;
    logic [31:0] s_rpc;
    int          s_lat;
    // observations of the last step
    logic [31:0] o_next, o_ipc, o_iout;
    bit          o_stall, o_iv, o_rv;
    logic [31:0] acc_q[$];
    logic [31:0] del_q[$];
    int          n_stall0, n_reqv, n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    task automatic model_clear();
        m_out = 0; m_stale = 0; m_held = 0;
        m_hdata = '0; m_hpc = '0; m_reqpc = '0;
        m_fetch = 0; m_drop = 0;
        mem_pend = 0; mem_dly = 0; mem_addr = '0;
        current_pc = '0;
    endtask

    // One clock cycle: drive at negedge, compare, update model, then the PC register at posedge
    task automatic step();
        bit rsp, acc, adv;
        @(negedge clk);
        redirect_valid  = s_redirect;
        redirect_pc     = s_rpc;
        id_ready        = s_id_ready;
        im.im_req_ready = s_ready;
        rsp             = mem_pend && (mem_dly == 0);
        im.im_rsp_valid = rsp;
        im.im_rsp_data  = rsp ? (s_bad_data ? 32'hDEAD_BEEF : mem_word(mem_addr)) : 32'h0;
        #1;
        o_next  = next_pc;
        o_stall = fetch_stall;
        o_iv    = inst_valid;
        o_iout  = inst_out;
        o_ipc   = inst_pc;
        o_rv    = im.im_req_valid;

        adv = m_held && s_id_ready && !s_redirect;
        chk("req_valid", o_rv, !m_out && !m_held);
        if (o_rv) chk("req_addr", im.im_req_addr, current_pc);
        chk("fetch_stall", o_stall, !(s_redirect || adv));
        chk("next_pc", o_next, s_redirect ? s_rpc : (adv ? current_pc + 32'd4 : current_pc));
        chk("inst_valid", o_iv, m_held);
        if (m_held) begin
            chk("inst_out", o_iout, m_hdata);
            chk("inst_pc", o_ipc, m_hpc);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch", perf_fetch, m_fetch);
        chk("perf_drop", perf_drop, m_drop);
`endif
        if (!o_stall) n_stall0++;
        if (o_rv) n_reqv++;
        if (o_iv && o_iout == 32'hDEAD_BEEF) n_bad++;
        acc = o_rv && s_ready;

        if (!m_out && !m_held) begin
            if (s_ready) begin
                m_out = 1; m_reqpc = current_pc; m_stale = s_redirect;
            end
        end else if (m_out) begin
            if (rsp) begin
                m_out = 0;
                if (m_stale || s_redirect) m_drop++;
                else begin
                    m_held = 1; m_hdata = im.im_rsp_data; m_hpc = m_reqpc;
                end
                m_stale = 0;
            end else if (s_redirect) begin
                m_stale = 1;
            end
        end else begin
            if (s_redirect) begin
                m_held = 0; m_drop++;
            end else if (s_id_ready) begin
                m_held = 0; m_fetch++; del_q.push_back(m_hpc);
            end
        end

        @(posedge clk);
        #1;
        if (rsp) mem_pend = 0;
        else if (mem_pend) mem_dly--;
        if (acc) begin
            mem_pend = 1; mem_dly = s_lat; mem_addr = im.im_req_addr;
            acc_q.push_back(im.im_req_addr);
        end
        if (!o_stall) current_pc = o_next;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 0; redirect_pc = '0; id_ready = 0;
        im.im_req_ready = 0; im.im_rsp_valid = 0; im.im_rsp_data = '0;
        s_redirect = 0; s_rpc = '0; s_id_ready = 0; s_ready = 0; s_bad_data = 0; s_lat = 0;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_out", inst_out, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_req_valid", im.im_req_valid, 1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drain to the request-issue point without accepting a new request
    task automatic go_idle();
        s_redirect = 0; s_id_ready = 1; s_ready = 0; s_bad_data = 0;
        for (int i = 0; i < 20; i++) begin
            if (!m_out && !m_held) break;
            step();
        end
        chk("idle_reached", {31'd0, (m_out || m_held)}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int unsigned d0;
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] p0;
`endif
        do_reset();

        // back-to-back fetch, zero-wait memory
        s_ready = 1; s_lat = 0; s_id_ready = 1;
        n_stall0 = 0;
        repeat (9) step();
        chk("seq_acc0", acc_q.size() > 0 ? acc_q[0] : 32'hX, 32'h0);
        chk("seq_acc1", acc_q.size() > 1 ? acc_q[1] : 32'hX, 32'h4);
        chk("seq_acc2", acc_q.size() > 2 ? acc_q[2] : 32'hX, 32'h8);
        chk("seq_del0", del_q.size() > 0 ? del_q[0] : 32'hX, 32'h0);
        chk("seq_del1", del_q.size() > 1 ? del_q[1] : 32'hX, 32'h4);
        chk("seq_del2", del_q.size() > 2 ? del_q[2] : 32'hX, 32'h8);
        chk("seq_stall0_cnt", n_stall0, 3);

        // ID stalled for 5 cycles in hold
        s_id_ready = 0;
        repeat (2) step();
        n_stall0 = 0; n_reqv = 0;
        repeat (5) step();
        chk("stall_no_adv", n_stall0, 0);
        chk("stall_no_req", n_reqv, 0);
        chk("stall_inst_pc", o_ipc, 32'hC);
        s_id_ready = 1;
        step();
        chk("stall_release_next", o_next, 32'h10);
        chk("stall_release_stall", o_stall, 0);

        // redirect while waiting; the late response must never reach ID
        n0 = acc_q.size(); n_bad = 0;
        s_lat = 2;
        step();
        s_redirect = 1; s_rpc = 32'h100; s_bad_data = 1;
        step();
        chk("wait_redir_next", o_next, 32'h100);
        s_redirect = 0;
        repeat (2) step();
        s_bad_data = 0; s_lat = 0;
        repeat (3) step();
        chk("wait_redir_acc", acc_q.size() > n0 + 1 ? acc_q[n0+1] : 32'hX, 32'h100);
        chk("wait_redir_nobad", n_bad, 0);

        // redirect and id_ready together in hold
        go_idle();
        s_ready = 1; s_lat = 0; s_id_ready = 0;
        repeat (2) step();
        d0 = m_drop;
`ifdef FETCH_PERF_CNT_EN
        p0 = perf_drop;
`endif
        s_redirect = 1; s_rpc = 32'h40; s_id_ready = 1;
        step();
        chk("hold_redir_next", o_next, 32'h40);
        chk("hold_redir_stall", o_stall, 0);
        s_redirect = 0; s_id_ready = 0; s_ready = 0;
        step();
        chk("hold_redir_iv", o_iv, 0);
        chk("hold_redir_drop", m_drop - d0, 1);
`ifdef FETCH_PERF_CNT_EN
        chk("hold_redir_perf", perf_drop - p0, 1);
`endif

        // two redirects against one outstanding request
        go_idle();
        n0 = acc_q.size(); d0 = m_drop;
        s_ready = 1; s_lat = 3; s_id_ready = 1;
        step();
        s_redirect = 1; s_rpc = 32'h200;
        step();
        s_rpc = 32'h300;
        step();
        s_redirect = 0; s_lat = 0;
        repeat (4) step();
        chk("dbl_redir_acc", acc_q.size() > n0 + 1 ? acc_q[n0+1] : 32'hX, 32'h300);
        chk("dbl_redir_drop", m_drop - d0, 1);

        // PC wrap at top of address space
        go_idle();
        s_ready = 0; s_redirect = 1; s_rpc = 32'hFFFF_FFFC;
        step();
        s_redirect = 0; s_ready = 1; s_lat = 0; s_id_ready = 1;
        repeat (3) step();
        chk("wrap_inst_pc", o_ipc, 32'hFFFF_FFFC);
        chk("wrap_next", o_next, 32'h0);
        chk("wrap_stall", o_stall, 0);

        // asynchronous reset while a request is outstanding
        go_idle();
        s_ready = 1; s_lat = 3;
        repeat (2) step();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_inst_valid", inst_valid, 0);
        chk("arst_inst_out", inst_out, 0);
        chk("arst_inst_pc", inst_pc, 0);
        chk("arst_req_valid", im.im_req_valid, 1);
`ifdef FETCH_PERF_CNT_EN
        chk("arst_perf_fetch", perf_fetch, 0);
        chk("arst_perf_drop", perf_drop, 0);
`endif
        do_reset();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            s_redirect = ($urandom % 10) == 0;
            s_rpc      = (($urandom % 8) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            s_id_ready = ($urandom % 4) != 0;
            s_ready    = ($urandom % 3) != 0;
            s_lat      = $urandom_range(0, 3);
            s_bad_data = 0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
